jt12_timer_ctrl: RTL and testbench
==================================

# jt12_timer_ctrl

Register-side controller for the FM timer pair. Decodes CPU writes to registers 0x24–0x27 into the timer A/B reload values, load levels, IRQ enables and one-clock flag-clear pulses. Generates the channel-3 CSM key-on strobe from timer A overflow and assembles the status byte, including the busy flag. Sits between the CPU register decoder and the dual timer, in the same `clk`/`clk_en` domain.

## Interface
- `BUSY_CNT`, 32: number of `clk_en` ticks busy stays high after a write (1..63).
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `clk_en`  in  1  clock enable (sample-rate sub-tick)
- `zero`  in  1  sample-period strobe, qualified by `clk_en`
- `reg_wr`  in  1  one-`clk` write strobe
- `reg_addr`  in  8  register number
- `reg_din`  in  8  write data
- `flag_A`, `flag_B`  in  1 each  timer flags
- `overflow_A`  in  1  timer A overflow (combinational, valid when `clk_en&zero`)
- `value_A`  out  10  timer A reload value
- `value_B`  out  8  timer B reload value
- `load_A`, `load_B`  out  1 each  timer run levels
- `enable_irq_A`, `enable_irq_B`  out  1 each  IRQ enables
- `clr_flag_A`, `clr_flag_B`  out  1 each  flag-clear pulses
- `ch3_mode`  out  2  channel-3 mode: 00 normal, 01 special, 10 CSM, 11 special
- `csm_keyon`  out  1  CSM key-on for all channel-3 operators
- `busy`  out  1  write-busy flag
- `status`  out  8  {`busy`, 5'b0, `flag_B`, `flag_A`}

## Operation
- A write is accepted on any `clk` edge with `reg_wr=1`, independent of `clk_en`.
- Register map:
  - 0x24: `value_A[9:2]` ← `din[7:0]`.
  - 0x25: `value_A[1:0]` ← `din[1:0]`. Other bits are ignored.
  - 0x26: `value_B` ← `din`.
  - 0x27: `load_A`←d0, `load_B`←d1, `enable_irq_A`←d2, `enable_irq_B`←d3, `ch3_mode`←d7:6. These are persistent.
  - 0x27 d4 fires the `clr_flag_A` pulse and d5 fires the `clr_flag_B` pulse. Neither bit is stored.
- Addresses outside 0x24–0x27 change no timer state but still trigger busy.
- The 0x24 and 0x25 halves update independently; there is no write-pairing latch.
- Busy:
  - Any write loads a 6-bit counter with `BUSY_CNT` and sets `busy`.
  - Each `clk_en` decrements the counter. `busy` drops when it reaches 0.
  - A write while busy is still accepted and restarts the count.
- CSM state, 1 bit:
  - IDLE→ON on `clk_en&zero&overflow_A&(ch3_mode==2'b10)`.
  - ON→IDLE on the next `clk_en&zero`. If the re-arm condition also holds on that edge, the state stays ON.
  - `csm_keyon` = state.
  - Writing `ch3_mode`≠10 forces the state to IDLE on the same edge.
- `status` is combinational from the current `busy`, `flag_B` and `flag_A`.

## Timing
- Reset: all outputs 0.
  - `value_A`=0, `value_B`=0, all loads, enables and clears 0, `ch3_mode`=00.
  - `csm_keyon`=0, `busy`=0, busy counter 0.
  - `status`=`{1'b0,5'b0,flag_B,flag_A}`.
- Reset mid-busy or mid-CSM returns to IDLE and not busy at the next edge.
- Register outputs change on the edge that samples `reg_wr`, so they are visible the cycle after the strobe.
- `clr_flag_*` is high for exactly 1 `clk` in the cycle after the write, whatever `clk_en` is doing.
- A write to 0x27 with both d4 and d5 set pulses both clears in the same cycle.
- `csm_keyon` rises one `clk` after the qualifying `clk_en&zero` edge. It stays high for exactly one sample period, i.e. until the following `clk_en&zero` edge.
- `busy` rises one `clk` after the write. With `clk_en` continuous it falls `BUSY_CNT` clocks later.
- When `reg_wr` and the final busy decrement fall on the same edge, the write wins: the counter reloads and `busy` stays 1.

## Test plan
- Reset with `flag_A`=`flag_B`=0 → every output 0 and `status`=0x00. Write 0x24=0xAB, then 0x25=0x03 → `value_A`=0x2AF. Write 0x26=0x5C → `value_B`=0x5C.
- Write 0x27=0x3F → `load_A`=`load_B`=1 and IRQ enables 1. `clr_flag_A`/`clr_flag_B` are 1 for a single clock. Read back `load_*` still 1 after 10 clocks and clears 0.
- `clk_en` every 2nd clock, `BUSY_CNT`=32, write 0x30 → `busy` high for 64 clocks. Second write at clock 40 → `busy` stays high until clock 104. `status[7]` tracks `busy`.
- `ch3_mode`=10 via 0x27=0x80, pulse `overflow_A` on a `clk_en&zero` edge → `csm_keyon`=1 for exactly one zero-to-zero period. Same stimulus with `ch3_mode`=01 → `csm_keyon` stays 0.
- `csm_keyon` high, then write 0x27=0x00 → `csm_keyon` is 0 the next clock.
- Assert `rst` while busy and while CSM is ON → `busy` and `csm_keyon` are both 0 the next clock, and the registers read 0.

Source files
------------

// File: rtl/jt12_timer_ctrl.sv
// Timer register decoder: 0x24-0x27 writes, CSM key-on strobe,
// write-busy counter and status byte for the FM timer pair.
module jt12_timer_ctrl #(
  parameter int BUSY_CNT = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_en,
  input  logic       zero,
  input  logic       reg_wr,
  input  logic [7:0] reg_addr,
  input  logic [7:0] reg_din,
  input  logic       flag_A,
  input  logic       flag_B,
  input  logic       overflow_A,
  output logic [9:0] value_A,
  output logic [7:0] value_B,
  output logic       load_A,
  output logic       load_B,
  output logic       enable_irq_A,
  output logic       enable_irq_B,
  output logic       clr_flag_A,
  output logic       clr_flag_B,
  output logic [1:0] ch3_mode,
  output logic       csm_keyon,
  output logic       busy,
  output logic [7:0] status
);

  localparam logic [5:0] BUSY_LD = 6'(BUSY_CNT);

  logic [5:0] busy_cnt;
  logic       csm_on;
  logic       wr24;
  logic       wr25;
  logic       wr26;
  logic       wr27;
  logic       tick_zero;

  assign wr24      = reg_wr && (reg_addr == 8'h24);
  assign wr25      = reg_wr && (reg_addr == 8'h25);
  assign wr26      = reg_wr && (reg_addr == 8'h26);
  assign wr27      = reg_wr && (reg_addr == 8'h27);
  assign tick_zero = clk_en && zero;

  always_ff @(posedge clk) begin
    if (rst) begin
      value_A      <= '0;
      value_B      <= '0;
      load_A       <= 1'b0;
      load_B       <= 1'b0;
      enable_irq_A <= 1'b0;
      enable_irq_B <= 1'b0;
      clr_flag_A   <= 1'b0;
      clr_flag_B   <= 1'b0;
      ch3_mode     <= 2'b00;
    end else begin
      clr_flag_A <= 1'b0;
      clr_flag_B <= 1'b0;
      unique case (1'b1)
        wr24: value_A[9:2] <= reg_din;
        wr25: value_A[1:0] <= reg_din[1:0];
        wr26: value_B      <= reg_din;
        wr27: begin
          load_A       <= reg_din[0];
          load_B       <= reg_din[1];
          enable_irq_A <= reg_din[2];
          enable_irq_B <= reg_din[3];
          clr_flag_A   <= reg_din[4];
          clr_flag_B   <= reg_din[5];
          ch3_mode     <= reg_din[7:6];
        end
        default: ;
      endcase
    end
  end

  // A write always wins over the decrement on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_cnt <= '0;
    end else if (reg_wr) begin
      busy_cnt <= BUSY_LD;
    end else if (clk_en && (busy_cnt != 6'd0)) begin
      busy_cnt <= busy_cnt - 6'd1;
    end
  end

  // Key-on lasts one sample period; leaving CSM mode kills it at once
  always_ff @(posedge clk) begin
    if (rst) begin
      csm_on <= 1'b0;
    end else if (wr27 && (reg_din[7:6] != 2'b10)) begin
      csm_on <= 1'b0;
    end else if (tick_zero) begin
      csm_on <= overflow_A && (ch3_mode == 2'b10);
    end
  end

  assign busy      = (busy_cnt != 6'd0);
  assign csm_keyon = csm_on;
  assign status    = {busy, 5'b0, flag_B, flag_A};

endmodule

// File: tb/tb_jt12_timer_ctrl.sv
// Directed self-checking bench for jt12_timer_ctrl.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_jt12_timer_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clk_en = 1'b0;
  logic       zero = 1'b0;
  logic       reg_wr = 1'b0;
  logic [7:0] reg_addr = '0;
  logic [7:0] reg_din = '0;
  logic       flag_A = 1'b0;
  logic       flag_B = 1'b0;
  logic       overflow_A = 1'b0;
  logic [9:0] value_A;
  logic [7:0] value_B;
  logic       load_A;
  logic       load_B;
  logic       enable_irq_A;
  logic       enable_irq_B;
  logic       clr_flag_A;
  logic       clr_flag_B;
  logic [1:0] ch3_mode;
  logic       csm_keyon;
  logic       busy;
  logic [7:0] status;

  int checks = 0;
  int failures = 0;

  jt12_timer_ctrl #(.BUSY_CNT(32)) dut (
    .clk(clk),
    .rst(rst),
    .clk_en(clk_en),
    .zero(zero),
    .reg_wr(reg_wr),
    .reg_addr(reg_addr),
    .reg_din(reg_din),
    .flag_A(flag_A),
    .flag_B(flag_B),
    .overflow_A(overflow_A),
    .value_A(value_A),
    .value_B(value_B),
    .load_A(load_A),
    .load_B(load_B),
    .enable_irq_A(enable_irq_A),
    .enable_irq_B(enable_irq_B),
    .clr_flag_A(clr_flag_A),
    .clr_flag_B(clr_flag_B),
    .ch3_mode(ch3_mode),
    .csm_keyon(csm_keyon),
    .busy(busy),
    .status(status)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    reg_wr   = 1'b1;
    reg_addr = a;
    reg_din  = d;
    tick();
    reg_wr   = 1'b0;
  endtask

  task automatic zero_edge(input logic ovf);
    clk_en     = 1'b1;
    zero       = 1'b1;
    overflow_A = ovf;
    tick();
    clk_en     = 1'b0;
    zero       = 1'b0;
    overflow_A = 1'b0;
  endtask

  task automatic drain();
    clk_en = 1'b1;
    repeat (40) tick();
    clk_en = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    tick();
    tick();
    chk("rst_value_A", value_A, 0);
    chk("rst_value_B", value_B, 0);
    chk("rst_ctl", {load_A, load_B, enable_irq_A, enable_irq_B}, 0);
    chk("rst_clr", {clr_flag_A, clr_flag_B}, 0);
    chk("rst_mode", ch3_mode, 0);
    chk("rst_csm", csm_keyon, 0);
    chk("rst_busy", busy, 0);
    chk("rst_status", status, 8'h00);
    rst = 1'b0;
    tick();
    flag_A = 1'b1;
    #1;
    chk("status_flagA", status, 8'h01);
    flag_A = 1'b0;
    flag_B = 1'b1;
    #1;
    chk("status_flagB", status, 8'h02);
    flag_B = 1'b0;

    wr(8'h24, 8'hAB);
    chk("valA_hi", value_A, 10'h2AC);
    chk("busy_rise", busy, 1);
    chk("status_busy", status, 8'h80);
    wr(8'h25, 8'hFF);
    chk("valA_lo", value_A, 10'h2AF);
    wr(8'h25, 8'h02);
    chk("valA_lo_only", value_A, 10'h2AE);
    wr(8'h25, 8'h03);
    chk("valA_full", value_A, 10'h2AF);
    wr(8'h26, 8'h5C);
    chk("valB", value_B, 8'h5C);
    chk("valA_kept", value_A, 10'h2AF);
    wr(8'h31, 8'hFF);
    chk("oob_valA", value_A, 10'h2AF);
    chk("oob_valB", value_B, 8'h5C);

    wr(8'h27, 8'h3F);
    chk("ctl_set", {load_A, load_B, enable_irq_A, enable_irq_B}, 4'hF);
    chk("clr_pulse", {clr_flag_A, clr_flag_B}, 2'b11);
    chk("mode_00", ch3_mode, 2'b00);
    tick();
    chk("clr_gone", {clr_flag_A, clr_flag_B}, 2'b00);
    repeat (9) tick();
    chk("ctl_hold", {load_A, load_B, enable_irq_A, enable_irq_B}, 4'hF);
    chk("clr_hold0", {clr_flag_A, clr_flag_B}, 2'b00);
    wr(8'h27, 8'h15);
    chk("ctl_mix", {load_A, load_B, enable_irq_A, enable_irq_B}, 4'hA);
    chk("clr_A_only", {clr_flag_A, clr_flag_B}, 2'b10);
    tick();
    chk("clr_A_gone", clr_flag_A, 0);

    drain();
    chk("busy_drained", busy, 0);
    reg_wr   = 1'b1;
    reg_addr = 8'h30;
    reg_din  = 8'h00;
    tick();
    reg_wr = 1'b0;
    for (int k = 1; k <= 70; k++) begin
      clk_en = (k % 2 == 0);
      tick();
      chk("busy_run1", busy, (k < 64) ? 1 : 0);
    end
    clk_en = 1'b0;
    drain();
    reg_wr   = 1'b1;
    reg_addr = 8'h30;
    tick();
    reg_wr = 1'b0;
    for (int k = 1; k <= 110; k++) begin
      clk_en = (k % 2 == 0);
      reg_wr = (k == 40);
      tick();
      chk("busy_run2", busy, (k < 104) ? 1 : 0);
      chk("status7_run2", status[7], (k < 104) ? 1 : 0);
    end
    reg_wr = 1'b0;
    clk_en = 1'b0;

    wr(8'h27, 8'h80);
    chk("mode_csm", ch3_mode, 2'b10);
    chk("csm_idle", csm_keyon, 0);
    zero_edge(1'b1);
    chk("csm_on", csm_keyon, 1);
    clk_en = 1'b1;
    repeat (3) tick();
    chk("csm_hold_en", csm_keyon, 1);
    clk_en = 1'b0;
    zero = 1'b1;
    tick();
    zero = 1'b0;
    chk("csm_hold_noen", csm_keyon, 1);
    zero_edge(1'b0);
    chk("csm_off", csm_keyon, 0);
    zero_edge(1'b1);
    zero_edge(1'b1);
    chk("csm_rearm", csm_keyon, 1);
    zero_edge(1'b0);
    chk("csm_rearm_off", csm_keyon, 0);

    wr(8'h27, 8'h40);
    zero_edge(1'b1);
    chk("csm_mode01", csm_keyon, 0);

    wr(8'h27, 8'h80);
    zero_edge(1'b1);
    chk("csm_on2", csm_keyon, 1);
    wr(8'h27, 8'h00);
    chk("csm_kill", csm_keyon, 0);

    wr(8'h27, 8'h83);
    zero_edge(1'b1);
    wr(8'h24, 8'hFF);
    chk("pre_rst_csm", csm_keyon, 1);
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    tick();
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_csm", csm_keyon, 0);
    chk("mid_rst_valA", value_A, 0);
    chk("mid_rst_valB", value_B, 0);
    chk("mid_rst_ctl", {load_A, load_B, ch3_mode}, 0);
    rst = 1'b0;
    tick();
    chk("post_rst_status", status, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
